i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
- Sequences the I2C master block from a command list held in an external synchronous ROM/BRAM, e.g. codec or display power-up init.
- Sits between the I2C block's register/trigger logic and the I2C master.
- Generates the master's SCL-rate enable and drives its enable, send byte, length and tri-state inputs.
- Waits for byte and buffer valid pulses and inserts bus-free gaps and programmable delays between transactions.

Parameters:
- pDivMax, 250, iSysClk cycles per oDivCke pulse; SCL toggles per pulse, so 250 @100MHz gives 200kHz.
- pCmdAw, 6, command memory address width (64 entries).
- pGapCyc, 150, cycles oI2CEn held low between transactions (tBUF ≥1.3us @100MHz).
- pWdtMax, 65535, watchdog limit in cycles per transaction (optional feature only).
- pRetryMax, 3, retries per command before error (optional feature only).

Ports:
- iSysClk  in  1  system clock, 100MHz.
- iSysRst  in  1  asynchronous active-low reset (0 = reset).
- iStart  in  1  1-cycle pulse; starts the sequence at address 0. Ignored while busy.
- oBusy  out  1  high from accepted iStart until DONE/ERROR.
- oDone  out  1  1-cycle pulse on END opcode.
- oErr  out  1  sticky error flag, cleared by iStart.
- oCmdAdrs  out  pCmdAw  command memory address.
- iCmdData  in  32  command word, valid 1 cycle after oCmdAdrs.
- oDivCke  out  1  SCL-rate enable to the master.
- oI2CEn  out  1  master enable.
- oTriState  out  1  master SDA tri-state control; 0 for all writes.
- oI2CSend  out  8  current byte to the master.
- oI2CBufLen  out  8  bytes in the current transaction.
- iI2CByteVd  in  1  master 1-byte-sent pulse.
- iI2CBufVd  in  1  master all-bytes-sent pulse.

Behaviour:
- Command word format by op = [31:30]:
  - 0 WR3: send [29:23] dev address with the write bit (0) appended, then [15:8] reg, then [7:0] data; BufLen = 3.
  - 1 WR2: send dev address byte, then [7:0]; BufLen = 2.
  - 2 WAIT: idle for [23:0] × 256 cycles; field 0 means no delay.
  - 3 END.
- Reset values: all outputs 0 except oTriState = 0, oI2CSend = 8'h00, oI2CBufLen = 8'd0, oCmdAdrs = 0. Divider counter 0. State IDLE.
- Divider: free-running counter 0..pDivMax-1. oDivCke = 1 for one cycle when the count is pDivMax-1. Runs in every state.
- State machine:
  - IDLE: on iStart → FETCH; oBusy = 1, oErr = 0, address = 0.
  - FETCH: address is presented; next cycle → LOAD.
  - LOAD: capture iCmdData into the command register, then decode:
    - WR2/WR3: load byte index 0; set oI2CSend and oI2CBufLen → XFER.
    - WAIT → DLY.
    - END → DONE.
  - XFER: oI2CEn = 1.
    - Each iI2CByteVd increments the byte index; oI2CSend updates to the next byte on the following cycle.
    - After the last byte, oI2CSend holds its value.
    - iI2CBufVd → GAP.
  - GAP: oI2CEn = 0 for pGapCyc cycles; address + 1 → FETCH.
  - DLY: count down; at 0, address + 1 → FETCH.
  - DONE: oDone pulse, oBusy = 0 → IDLE.
  - ERROR: oErr = 1, oBusy = 0, oI2CEn = 0 → IDLE.
- Boundary cases:
  - iI2CByteVd and iI2CBufVd in the same cycle: BufVd wins.
  - Address at maximum with no END: wraps to 0; the sequence relies on END.
  - Reset mid-transfer drops oI2CEn to 0 immediately (asynchronous), which returns the master to disconnect.
  - iStart while busy: ignored.
  - iI2CByteVd outside XFER: ignored.
  - Latency: iStart to oI2CEn rising = 3 cycles (IDLE→FETCH→LOAD→XFER).

Optional Feature:
- Macro: I2C_CMD_SEQUENCER_WDT_EN.
- Defined:
  - A watchdog counts cycles in XFER.
  - Reaching pWdtMax drops oI2CEn and enters GAP without advancing the address, then retries the same command.
  - A retry counter is reset per new command. Exceeding pRetryMax → ERROR.
- Undefined:
  - No watchdog or counters are synthesized.
  - XFER waits indefinitely; ERROR is unreachable and oErr stays 0.

Decomposition:
- Shared package i2c_seq_pkg holds:
  - op codes (WR3, WR2, WAIT, END);
  - state encodings;
  - command field bit positions;
  - the WAIT prescale (256).
- One sub-module, i2c_cke_div: the pDivMax divider producing oDivCke.

Test Plan:
- ROM {WR3 dev 0x1A reg 0x05 data 0x3C, END}; iStart; bench emits ByteVd ×3, then BufVd.
  - Expect oI2CSend 0x34 → 0x05 → 0x3C, oI2CBufLen = 3, oI2CEn high until BufVd, then oDone.
- WR2 followed by WR2: oI2CEn low exactly 150 cycles between transactions; second oI2CBufLen = 2.
- WAIT field 4: gap from end of WAIT fetch to next oI2CEn rising = 1024 + 3 cycles.
- iStart repeated while busy, and reset asserted mid-XFER:
  - repeated iStart is ignored;
  - on reset, oI2CEn = 0 same cycle and state returns to IDLE.
- WDT_EN, pWdtMax = 100, bench never emits BufVd: expect 4 attempts (1 + 3 retries), then oErr = 1, oBusy = 0.
- Divider: 1000-cycle window gives 4 oDivCke pulses spaced exactly 250 cycles apart.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - opcodes, states, command field layout and byte helpers for i2c_cmd_sequencer
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        OP_WR3  = 2'd0,
        OP_WR2  = 2'd1,
        OP_WAIT = 2'd2,
        OP_END  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_XFER  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DLY   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_e;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 30;
    localparam int DEV_HI  = 29;
    localparam int DEV_LO  = 23;
    localparam int REG_HI  = 15;
    localparam int REG_LO  = 8;
    localparam int DAT_HI  = 7;
    localparam int DAT_LO  = 0;
    localparam int WAIT_HI = 23;
    localparam int WAIT_LO = 0;

    localparam int WAIT_PRESCALE = 256;

    typedef struct packed {
        op_e        op;
        logic [6:0] dev;
        logic [7:0] regAdr;
        logic [7:0] data;
    } cmd_t;

    // Byte 0 is always the device address with the write bit appended
    function automatic logic [7:0] cmdByte(input cmd_t c, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {c.dev, 1'b0};
            2'd1:    b = (c.op == OP_WR3) ? c.regAdr : c.data;
            default: b = c.data;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] cmdLen(input op_e op);
        return (op == OP_WR3) ? 8'd3 : 8'd2;
    endfunction

endpackage

// File: rtl/i2c_cke_div.sv
// rtl/i2c_cke_div.sv - free-running divider producing the one-cycle SCL-rate enable
module i2c_cke_div #(
    parameter int pDivMax = 250
) (
    input  logic iSysClk,
    input  logic iSysRst,
    output logic oDivCke
);

    localparam int CW = (pDivMax > 1) ? $clog2(pDivMax) : 1;
    localparam logic [CW-1:0] LAST = CW'(pDivMax - 1);

    logic [CW-1:0] cntQ;

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst)
            cntQ <= '0;
        else if (cntQ == LAST)
            cntQ <= '0;
        else
            cntQ <= cntQ + CW'(1);
    end

    assign oDivCke = (cntQ == LAST);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - ROM-driven I2C master sequencer; watchdog/retry under I2C_CMD_SEQUENCER_WDT_EN
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int pDivMax = 250,
    parameter int pCmdAw  = 6,
    parameter int pGapCyc = 150
`ifdef I2C_CMD_SEQUENCER_WDT_EN
   ,parameter int pWdtMax   = 65535,
    parameter int pRetryMax = 3
`endif
) (
    input  logic              iSysClk,
    input  logic              iSysRst,
    input  logic              iStart,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [pCmdAw-1:0] oCmdAdrs,
    input  logic [31:0]       iCmdData,
    output logic              oDivCke,
    output logic              oI2CEn,
    output logic              oTriState,
    output logic [7:0]        oI2CSend,
    output logic [7:0]        oI2CBufLen,
    input  logic              iI2CByteVd,
    input  logic              iI2CBufVd
);

    // The FETCH and LOAD of the next command complete the bus-free time
    localparam int GAP_CYC = (pGapCyc > 3) ? pGapCyc - 2 : 1;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam int WAIT_SHIFT = $clog2(WAIT_PRESCALE);

    state_e            stateQ, stateD;
    logic [pCmdAw-1:0] addrQ, addrD;
    cmd_t              cmdQ, cmdD, romCmd;
    logic [1:0]        idxQ, idxD, nextIdx;
    logic [7:0]        sendQ, sendD, lenQ, lenD;
    logic [31:0]       dlyQ, dlyD;
    logic [GW-1:0]     gapQ, gapD;

`ifdef I2C_CMD_SEQUENCER_WDT_EN
    localparam int WW = $clog2(pWdtMax + 1);
    localparam int RW = $clog2(pRetryMax + 2);
    logic [WW-1:0] wdtQ, wdtD;
    logic [RW-1:0] retryQ, retryD;
    logic          againQ, againD, errQ, errD;
`endif

    i2c_cke_div #(.pDivMax(pDivMax)) uCkeDiv (
        .iSysClk (iSysClk),
        .iSysRst (iSysRst),
        .oDivCke (oDivCke)
    );

    assign romCmd = '{op:     op_e'(iCmdData[OP_HI:OP_LO]),
                      dev:    iCmdData[DEV_HI:DEV_LO],
                      regAdr: iCmdData[REG_HI:REG_LO],
                      data:   iCmdData[DAT_HI:DAT_LO]};

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            stateQ <= ST_IDLE;
            addrQ  <= '0;
            cmdQ   <= '0;
            idxQ   <= '0;
            sendQ  <= '0;
            lenQ   <= '0;
            dlyQ   <= '0;
            gapQ   <= '0;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
            wdtQ   <= '0;
            retryQ <= '0;
            againQ <= 1'b0;
            errQ   <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            addrQ  <= addrD;
            cmdQ   <= cmdD;
            idxQ   <= idxD;
            sendQ  <= sendD;
            lenQ   <= lenD;
            dlyQ   <= dlyD;
            gapQ   <= gapD;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
            wdtQ   <= wdtD;
            retryQ <= retryD;
            againQ <= againD;
            errQ   <= errD;
`endif
        end
    end

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        cmdD    = cmdQ;
        idxD    = idxQ;
        sendD   = sendQ;
        lenD    = lenQ;
        dlyD    = dlyQ;
        gapD    = gapQ;
        nextIdx = idxQ + 2'd1;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
        wdtD    = wdtQ;
        retryD  = retryQ;
        againD  = againQ;
        errD    = errQ;
`endif
        case (stateQ)
            ST_IDLE: begin
                if (iStart) begin
                    stateD = ST_FETCH;
                    addrD  = '0;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                    retryD = '0;
                    againD = 1'b0;
                    errD   = 1'b0;
`endif
                end
            end
            ST_FETCH: stateD = ST_LOAD;
            ST_LOAD: begin
                cmdD = romCmd;
                case (romCmd.op)
                    OP_WR3, OP_WR2: begin
                        idxD   = '0;
                        sendD  = cmdByte(romCmd, 2'd0);
                        lenD   = cmdLen(romCmd.op);
                        stateD = ST_XFER;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                        wdtD   = '0;
`endif
                    end
                    OP_WAIT: begin
                        dlyD   = 32'(iCmdData[WAIT_HI:WAIT_LO]) << WAIT_SHIFT;
                        stateD = ST_DLY;
                    end
                    default: stateD = ST_DONE;
                endcase
            end
            ST_XFER: begin
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                wdtD = wdtQ + WW'(1);
`endif
                if (iI2CBufVd) begin
                    stateD = ST_GAP;
                    gapD   = GAP_LOAD;
                end
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                else if (wdtQ == WW'(pWdtMax - 1)) begin
                    if (retryQ == RW'(pRetryMax)) begin
                        stateD = ST_ERROR;
                        errD   = 1'b1;
                    end else begin
                        stateD = ST_GAP;
                        gapD   = GAP_LOAD;
                        retryD = retryQ + RW'(1);
                        againD = 1'b1;
                    end
                end
`endif
                else if (iI2CByteVd && (8'(nextIdx) < lenQ)) begin
                    idxD  = nextIdx;
                    sendD = cmdByte(cmdQ, nextIdx);
                end
            end
            ST_GAP: begin
                if (gapQ == '0) begin
                    stateD = ST_FETCH;
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                    // A timed-out command is refetched from the same address
                    if (againQ) begin
                        againD = 1'b0;
                    end else begin
                        addrD  = addrQ + pCmdAw'(1);
                        retryD = '0;
                    end
`else
                    addrD  = addrQ + pCmdAw'(1);
`endif
                end else begin
                    gapD = gapQ - GW'(1);
                end
            end
            ST_DLY: begin
                if (dlyQ == '0) begin
                    stateD = ST_FETCH;
                    addrD  = addrQ + pCmdAw'(1);
`ifdef I2C_CMD_SEQUENCER_WDT_EN
                    retryD = '0;
`endif
                end else begin
                    dlyD = dlyQ - 32'd1;
                end
            end
            ST_DONE:  stateD = ST_IDLE;
            ST_ERROR: stateD = ST_IDLE;
            default:  stateD = ST_IDLE;
        endcase
    end

    assign oCmdAdrs   = addrQ;
    assign oI2CSend   = sendQ;
    assign oI2CBufLen = lenQ;
    assign oTriState  = 1'b0;
    assign oI2CEn     = (stateQ == ST_XFER);
    assign oDone      = (stateQ == ST_DONE);
    assign oBusy      = !(stateQ inside {ST_IDLE, ST_DONE, ST_ERROR});
`ifdef I2C_CMD_SEQUENCER_WDT_EN
    assign oErr       = errQ;
`else
    assign oErr       = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - randomized self-checking bench for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;

    localparam int GAP = 150;
    localparam int DIV = 250;
    localparam logic [31:0] END_W = 32'hC000_0000;

    logic        iSysClk = 1'b0;
    logic        iSysRst = 1'b0;
    logic        iStart = 1'b0;
    logic        iI2CByteVd = 1'b0;
    logic        iI2CBufVd = 1'b0;
    logic [31:0] iCmdData;
    logic        oBusy, oDone, oErr, oDivCke, oI2CEn, oTriState;
    logic [5:0]  oCmdAdrs;
    logic [7:0]  oI2CSend, oI2CBufLen;

    logic [31:0] rom [64];
    int nVec = 0;
    int nErr = 0;

    always #5 iSysClk = ~iSysClk;
    always @(posedge iSysClk) iCmdData <= rom[oCmdAdrs];

    i2c_cmd_sequencer #(
        .pDivMax (DIV),
        .pCmdAw  (6),
        .pGapCyc (GAP)
`ifdef I2C_CMD_SEQUENCER_WDT_EN
       ,.pWdtMax   (100),
        .pRetryMax (3)
`endif
    ) dut (
        .iSysClk    (iSysClk),
        .iSysRst    (iSysRst),
        .iStart     (iStart),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr),
        .oCmdAdrs   (oCmdAdrs),
        .iCmdData   (iCmdData),
        .oDivCke    (oDivCke),
        .oI2CEn     (oI2CEn),
        .oTriState  (oTriState),
        .oI2CSend   (oI2CSend),
        .oI2CBufLen (oI2CBufLen),
        .iI2CByteVd (iI2CByteVd),
        .iI2CBufVd  (iI2CBufVd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: command semantics in plain arithmetic
    function automatic int opOf(input logic [31:0] w);
        return int'(w >> 30);
    endfunction
    function automatic int xferLen(input logic [31:0] w);
        return (opOf(w) == 0) ? 3 : 2;
    endfunction
    function automatic logic [7:0] xferByte(input logic [31:0] w, input int k);
        int dev;
        dev = int'((w >> 23) & 32'h7F);
        if (k == 0) return 8'(dev * 2);
        if (opOf(w) == 0 && k == 1) return 8'((w >> 8) & 32'hFF);
        return 8'(w & 32'hFF);
    endfunction
    function automatic int waitCost(input logic [31:0] w);
        return int'(w & 32'hFF_FFFF) * 256 + 3;
    endfunction
    function automatic logic [31:0] mkWr3(input logic [6:0] dev, input logic [7:0] r, input logic [7:0] d);
        return {2'd0, dev, 7'd0, r, d};
    endfunction
    function automatic logic [31:0] mkWr2(input logic [6:0] dev, input logic [7:0] d);
        return {2'd1, dev, 15'd0, d};
    endfunction
    function automatic logic [31:0] mkWait(input logic [23:0] f);
        return {2'd2, 6'd0, f};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 64; i++) rom[i] = END_W;
    endtask

    task automatic waitHigh(input int which, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge iSysClk);
            iStart = 1'b0;
            iI2CBufVd = 1'b0;
            iI2CByteVd = 1'b0;
            n++;
            if ((which == 0) ? (oI2CEn === 1'b1) : (oDone === 1'b1)) return;
        end
        n = -1;
    endtask

    task automatic doReset();
        @(negedge iSysClk);
        iSysRst = 1'b0;
        @(negedge iSysClk);
        iSysRst = 1'b1;
    endtask

    task automatic runSeq(input int maxXfers, input int collideAt, output logic [7:0] lastByte);
        int addr, waits, nXfer, n, lim, len, used;
        logic [31:0] w;
        bit first;
        addr = 0; waits = 0; nXfer = 0; used = 0; first = 1'b1;
        lastByte = 8'h00;
        @(negedge iSysClk);
        iStart = 1'b1;
        for (int step = 0; step < 200; step++) begin
            w = rom[addr];
            if (opOf(w) == 2) begin
                waits += waitCost(w);
                addr = (addr + 1) % 64;
                continue;
            end
            lim = (first ? 3 : GAP + 1) + waits - used;
            used = 0;
            if (opOf(w) == 3) begin
                waitHigh(1, lim + 20, n);
                chk("done_lat", n, lim);
                chk("done_busy", oBusy, 1'b0);
                @(negedge iSysClk);
                chk("done_pulse", oDone, 1'b0);
                return;
            end
            waitHigh(0, lim + 20, n);
            chk("en_lat", n, lim);
            chk("busy", oBusy, 1'b1);
            chk("buflen", oI2CBufLen, xferLen(w));
            chk("send0", oI2CSend, xferByte(w, 0));
            iStart = 1'b1;
            @(negedge iSysClk);
            iStart = 1'b0;
            chk("start_ign_adr", oCmdAdrs, addr);
            chk("start_ign_en", oI2CEn, 1'b1);
            len = xferLen(w);
            if (nXfer == collideAt) begin
                iI2CByteVd = 1'b1;
                iI2CBufVd = 1'b1;
                @(negedge iSysClk);
                iI2CByteVd = 1'b0;
                iI2CBufVd = 1'b0;
                chk("collide_en", oI2CEn, 1'b0);
                chk("collide_send", oI2CSend, xferByte(w, 0));
                lastByte = xferByte(w, 0);
                used = 1;
            end else begin
                for (int b = 0; b < len; b++) begin
                    repeat ($urandom_range(0, 3)) @(negedge iSysClk);
                    iI2CByteVd = 1'b1;
                    @(negedge iSysClk);
                    iI2CByteVd = 1'b0;
                    chk("send_next", oI2CSend, xferByte(w, (b + 1 < len) ? b + 1 : len - 1));
                end
                chk("en_hold", oI2CEn, 1'b1);
                iI2CBufVd = 1'b1;
                lastByte = xferByte(w, len - 1);
            end
            nXfer++;
            first = 1'b0;
            waits = 0;
            addr = (addr + 1) % 64;
            if (nXfer == maxXfers) begin
                @(negedge iSysClk);
                iI2CBufVd = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int pulses[$];
        int n, rises;
        logic prevEn;
        logic [7:0] lb;
        logic [31:0] r;

        clearRom();
        #1;
        chk("rst_en", oI2CEn, 1'b0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_err", oErr, 1'b0);
        chk("rst_tri", oTriState, 1'b0);
        chk("rst_send", oI2CSend, 8'h00);
        chk("rst_len", oI2CBufLen, 8'd0);
        chk("rst_adr", oCmdAdrs, 6'd0);
        chk("rst_cke", oDivCke, 1'b0);
        @(negedge iSysClk);
        iSysRst = 1'b1;

        for (int c = 0; c < 1000; c++) begin
            @(negedge iSysClk);
            if (oDivCke) pulses.push_back(c);
        end
        chk("cke_count", pulses.size(), 4);
        for (int i = 1; i < pulses.size(); i++)
            chk("cke_spacing", pulses[i] - pulses[i-1], DIV);

        clearRom();
        rom[0] = mkWr3(7'h1A, 8'h05, 8'h3C);
        runSeq(99, -1, lb);

        @(negedge iSysClk);
        iI2CByteVd = 1'b1;
        @(negedge iSysClk);
        iI2CByteVd = 1'b0;
        chk("idle_bytevd_send", oI2CSend, lb);
        chk("idle_bytevd_busy", oBusy, 1'b0);

        clearRom();
        rom[0] = mkWr2(7'h50, 8'hA5);
        rom[1] = mkWr2(7'h21, 8'h0F);
        runSeq(99, -1, lb);

        clearRom();
        rom[0] = mkWait(24'd4);
        rom[1] = mkWr2(7'h33, 8'h77);
        runSeq(99, -1, lb);

        clearRom();
        rom[0] = mkWr3(7'h12, 8'h34, 8'h56);
        rom[1] = mkWr2(7'h44, 8'h99);
        runSeq(99, 0, lb);

        clearRom();
        rom[0] = mkWr2(7'h6C, 8'h81);
        for (int i = 1; i < 64; i++) rom[i] = mkWait(24'd0);
        runSeq(2, -1, lb);
        doReset();

        clearRom();
        rom[0] = mkWr2(7'h3F, 8'hC3);
        @(negedge iSysClk);
        iStart = 1'b1;
        waitHigh(0, 30, n);
        chk("pre_rst_en", oI2CEn, 1'b1);
        #2 iSysRst = 1'b0;
        #1;
        chk("midrst_en", oI2CEn, 1'b0);
        chk("midrst_busy", oBusy, 1'b0);
        chk("midrst_adr", oCmdAdrs, 6'd0);
        chk("midrst_send", oI2CSend, 8'h00);
        chk("midrst_len", oI2CBufLen, 8'd0);
        @(negedge iSysClk);
        iSysRst = 1'b1;
        @(negedge iSysClk);
        chk("postrst_en", oI2CEn, 1'b0);
        chk("postrst_busy", oBusy, 1'b0);

        for (int t = 0; t < 4; t++) begin
            int cnt;
            clearRom();
            cnt = $urandom_range(2, 5);
            for (int i = 0; i < cnt; i++) begin
                r = $urandom();
                case ($urandom_range(0, 2))
                    0: rom[i] = {2'd0, r[29:0]};
                    1: rom[i] = {2'd1, r[29:0]};
                    default: rom[i] = mkWait(24'($urandom_range(0, 2)));
                endcase
            end
            runSeq(99, (t % 2 == 1) ? int'($urandom_range(0, 1)) : -1, lb);
        end

        chk("tri_final", oTriState, 1'b0);
        chk("err_final", oErr, 1'b0);

`ifdef I2C_CMD_SEQUENCER_WDT_EN
        clearRom();
        rom[0] = mkWr2(7'h2B, 8'h11);
        @(negedge iSysClk);
        iStart = 1'b1;
        rises = 0;
        prevEn = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge iSysClk);
            iStart = 1'b0;
            if (oI2CEn && !prevEn) rises++;
            prevEn = oI2CEn;
            if (oErr) break;
        end
        chk("wdt_attempts", rises, 4);
        chk("wdt_err", oErr, 1'b1);
        chk("wdt_busy", oBusy, 1'b0);
        chk("wdt_en", oI2CEn, 1'b0);
        @(negedge iSysClk);
        iStart = 1'b1;
        @(negedge iSysClk);
        iStart = 1'b0;
        chk("wdt_err_clear", oErr, 1'b0);
        doReset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
